// File: rtl/itof_share_arb.sv
// Round-robin share of one fixed-latency int->float converter among NREQ requesters,
// with tag tracking and a credit-guarded result FIFO. Optional perf counters: ITOF_ARB_PERF_EN.
module itof_share_arb #(
   parameter int NREQ    = 4,
   parameter int CVT_LAT = 2,
   parameter int DEPTH   = 4
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NREQ-1:0]           req_valid,
   input  logic [32*NREQ-1:0]        req_data,
   output logic [NREQ-1:0]           req_ready,
   output logic [31:0]               cvt_x,
   input  logic [31:0]               cvt_y,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [31:0]               rsp_data,
   output logic [$clog2(NREQ)-1:0]   rsp_id
`ifdef ITOF_ARB_PERF_EN
   ,
   output logic [31:0]               perf_busy,
   output logic [31:0]               perf_stall
`endif
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]     req_word [NREQ];
   logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [CW-1:0]   occ_reg, occ_next;
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic            tag_v_reg  [CVT_LAT];
   logic [IDW-1:0]  tag_id_reg [CVT_LAT];
   logic [31:0]     mem_data [DEPTH];
   logic [IDW-1:0]  mem_id   [DEPTH];
   logic [IDW-1:0]  win, cand;
   logic            found, credit_ok, issue, push, pop;
   logic [IDW-1:0]  push_id;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_split
         assign req_word[gi] = req_data[32*gi +: 32];
      end
   endgenerate

   assign credit_ok = (cnt_reg < CW'(DEPTH));

   // First valid requester at or after rr_ptr wins; grants are gated by credit and reset.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = IDW'((int'(rr_ptr_reg) + off) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      issue     = found && credit_ok && rstn;
      req_ready = '0;
      if (issue) req_ready[win] = 1'b1;
      cvt_x       = issue ? req_word[win] : 32'h0;
      rr_ptr_next = rr_ptr_reg;
      if (issue) rr_ptr_next = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
   end

   assign push      = tag_v_reg[CVT_LAT-1];
   assign push_id   = tag_id_reg[CVT_LAT-1];
   assign rsp_valid = (occ_reg != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign rsp_data  = rsp_valid ? mem_data[rd_ptr_reg] : 32'h0;
   assign rsp_id    = rsp_valid ? mem_id[rd_ptr_reg] : '0;

   // A tag moving from pipe to FIFO keeps its credit; only issue and pop change cnt.
   always_comb begin
      cnt_next = cnt_reg;
      case ({issue, pop})
         2'b10:   cnt_next = cnt_reg + 1'b1;
         2'b01:   cnt_next = cnt_reg - 1'b1;
         default: cnt_next = cnt_reg;
      endcase
      occ_next = occ_reg;
      if (push && !pop)      occ_next = occ_reg + 1'b1;
      else if (!push && pop) occ_next = occ_reg - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr_reg <= '0;
         cnt_reg    <= '0;
         occ_reg    <= '0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
         cnt_reg    <= cnt_next;
         occ_reg    <= occ_next;
         if (push) wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < CVT_LAT; i++) begin
         if (!rstn)       tag_v_reg[i] <= 1'b0;
         else if (i == 0) tag_v_reg[i] <= issue;
         else             tag_v_reg[i] <= tag_v_reg[i-1];
         tag_id_reg[i] <= (i == 0) ? win : tag_id_reg[(i == 0) ? 0 : i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr_reg] <= cvt_y;
         mem_id[wr_ptr_reg]   <= push_id;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) assert (!(push && (occ_reg == CW'(DEPTH)) && !pop));
   end

`ifdef ITOF_ARB_PERF_EN
   logic [31:0] busy_reg, stall_reg;
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy_reg  <= '0;
         stall_reg <= '0;
      end else begin
         if (issue && (busy_reg != 32'hFFFFFFFF)) busy_reg <= busy_reg + 1'b1;
         if ((|req_valid) && !credit_ok && (stall_reg != 32'hFFFFFFFF))
            stall_reg <= stall_reg + 1'b1;
      end
   end
   assign perf_busy  = busy_reg;
   assign perf_stall = stall_reg;
`endif
endmodule

// File: tb/tb_itof_share_arb.sv
// Directed bench for itof_share_arb with a behavioural converter and an itof reference.
module tb_itof_share_arb;
   localparam int NREQ = 4, CVT_LAT = 2, DEPTH = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic [3:0]      req_valid = '0;
   logic [127:0]    req_data = '0;
   logic [3:0]      req_ready;
   logic [31:0]     cvt_x, cvt_y;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [31:0]     rsp_data;
   logic [1:0]      rsp_id;
`ifdef ITOF_ARB_PERF_EN
   logic [31:0]     perf_busy, perf_stall;
`endif
   int checks = 0;
   int failures = 0;

   itof_share_arb #(.NREQ(NREQ), .CVT_LAT(CVT_LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .cvt_x(cvt_x), .cvt_y(cvt_y), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ITOF_ARB_PERF_EN
      , .perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_itof(input logic [31:0] x);
      logic s;
      logic [31:0] a;
      logic [63:0] m, rem, half;
      int p, sh;
      if (x == 32'h0) return 32'h0;
      s = x[31];
      a = s ? (~x + 32'd1) : x;
      p = 31;
      while (!a[p]) p--;
      m = {32'h0, a};
      if (p <= 23) begin
         m = m << (23 - p);
      end else begin
         sh   = p - 23;
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         m    = m >> sh;
         if (rem > half || (rem == half && m[0])) m = m + 64'd1;
         if (m == (64'd1 << 24)) begin
            m = m >> 1;
            p = p + 1;
         end
      end
      return {s, 8'(p + 127), m[22:0]};
   endfunction

   // Converter: CVT_LAT register stages, reset together with the arbiter.
   logic [31:0] cvt_pipe [CVT_LAT];
   always_ff @(posedge clk) begin
      for (int i = 0; i < CVT_LAT; i++) begin
         if (!rstn)       cvt_pipe[i] <= 32'h0;
         else if (i == 0) cvt_pipe[i] <= ref_itof(cvt_x);
         else             cvt_pipe[i] <= cvt_pipe[(i == 0) ? 0 : i-1];
      end
   end
   assign cvt_y = cvt_pipe[CVT_LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      tick(); tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; req_valid = 4'b1111; req_data = {32'd4, 32'd3, 32'd2, 32'd1};
      tick(); tick();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++; if (rsp_data !== 32'h0 || rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp got=%h/%0d want=0/0", rsp_data, rsp_id); end
      checks++; if (cvt_x !== 32'h0) begin failures++; $display("FAIL reset_cvt_x got=%h want=0", cvt_x); end
`ifdef ITOF_ARB_PERF_EN
      checks++; if (perf_busy !== 32'd0 || perf_stall !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_busy, perf_stall); end
`endif
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      rsp_ready = 1'b1; req_valid = 4'b0001; req_data[31:0] = 32'h00000001;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001 || cvt_x !== 32'h1) begin failures++; $display("FAIL single_grant got=%b/%h want=0001/00000001", req_ready, cvt_x); end
      tick(); req_valid = '0;
      for (int k = 1; k <= CVT_LAT; k++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early k=%0d got=%b want=0", k, rsp_valid); end
         tick();
      end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h3F800000 || rsp_id !== 2'd0) begin
         failures++; $display("FAIL single_rsp got=%b/%h/%0d want=1/3f800000/0", rsp_valid, rsp_data, rsp_id); end
      tick();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_dup got=%b want=0", rsp_valid); end
      $display("test_single: rsp %h id %0d", 32'h3F800000, 0);
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_f [4];
      exp_f[0] = 32'hBF800000; exp_f[1] = 32'h00000000; exp_f[2] = 32'h40000000; exp_f[3] = 32'hCF000000;
      do_reset();
      rsp_ready = 1'b1; req_valid = 4'b1111;
      req_data = {32'h80000000, 32'h00000002, 32'h00000000, 32'hFFFFFFFF};
      for (int c = 0; c <= 10; c++) begin
         if (c == 8) req_valid = '0;
         @(negedge clk);
         if (c < 8) begin
            checks++; if (req_ready !== (4'b0001 << (c % 4))) begin failures++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, 4'b0001 << (c % 4)); end
         end
         if (c >= 3) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c-3) % 4) || rsp_data !== exp_f[(c-3) % 4]) begin
               failures++; $display("FAIL rr_rsp c=%0d got=%b/%h/%0d want=1/%h/%0d", c, rsp_valid, rsp_data, rsp_id, exp_f[(c-3)%4], (c-3)%4); end
            $display("test_round_robin: c=%0d rsp %h id %0d", c, rsp_data, rsp_id);
         end
         tick();
      end
   endtask

   task automatic test_credit_stall();
      logic [31:0] exp_f [4];
      int hs, nxt;
      logic got;
      exp_f[0] = 32'h3F800000; exp_f[1] = 32'h40000000; exp_f[2] = 32'h40400000; exp_f[3] = 32'h40800000;
      do_reset();
      hs = 0; nxt = 1;
      req_valid = 4'b0010; req_data[63:32] = 32'd1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         got = req_ready[1];
         if (got) hs++;
`ifdef ITOF_ARB_PERF_EN
         if (c == 4) begin
            checks++; if (perf_busy !== 32'd4) begin failures++; $display("FAIL perf_busy got=%0d want=4", perf_busy); end
         end
         if (c >= 4) begin
            checks++; if (perf_stall !== 32'(c - 4)) begin failures++; $display("FAIL perf_stall c=%0d got=%0d want=%0d", c, perf_stall, c-4); end
         end
`endif
         tick();
         if (got) begin nxt++; req_data[63:32] = 32'(nxt); end
      end
      checks++; if (hs != DEPTH) begin failures++; $display("FAIL stall_handshakes got=%0d want=%0d", hs, DEPTH); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready got=%b want=0000", req_ready); end
      rsp_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_f[r] || rsp_id !== 2'd1) begin
            failures++; $display("FAIL stall_rsp r=%0d got=%b/%h/%0d want=1/%h/1", r, rsp_valid, rsp_data, rsp_id, exp_f[r]); end
         if (r == 0) begin
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_early_credit got=%b want=0000", req_ready); end
         end
         if (r == 1) begin
            checks++; if (req_ready !== 4'b0010 || cvt_x !== 32'd5) begin failures++; $display("FAIL stall_resume got=%b/%h want=0010/5", req_ready, cvt_x); end
         end
         $display("test_credit_stall: r=%0d rsp %h id %0d", r, rsp_data, rsp_id);
         tick();
         if (r == 1) req_valid = '0;
      end
   endtask

   task automatic test_pop_issue_same_cycle();
      logic [31:0] q_data [$];
      logic [1:0]  q_id [$];
      logic [31:0] ed;
      logic [1:0]  ei;
      do_reset();
      for (int c = 0; c < 118; c++) begin
         if (c < 3) begin
            req_valid = 4'b0001; req_data[31:0] = 32'(10 + c); rsp_ready = 1'b0;
         end else if (c < 5) begin
            req_valid = '0; rsp_ready = 1'b0;
         end else if (c == 5) begin
            req_valid = 4'b0001; req_data[31:0] = 32'd100; rsp_ready = 1'b1;
         end else if (c < 106) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
            rsp_ready = 1'($urandom_range(0, 1));
         end else begin
            req_valid = '0; rsp_ready = 1'b1;
         end
         @(negedge clk);
         if (c == 5) begin
            checks++; if (dut.cnt_reg !== 3'd3) begin failures++; $display("FAIL same_cnt_before got=%0d want=3", dut.cnt_reg); end
            checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b1) begin failures++; $display("FAIL same_both got=%b/%b want=0001/1", req_ready, rsp_valid); end
         end
         if (c == 6) begin
            checks++; if (dut.cnt_reg !== 3'd3) begin failures++; $display("FAIL same_cnt_after got=%0d want=3", dut.cnt_reg); end
         end
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (q_data.size() == 0) begin
               failures++; $display("FAIL sb_extra c=%0d got=%h/%0d want=none", c, rsp_data, rsp_id);
            end else begin
               ed = q_data.pop_front(); ei = q_id.pop_front();
               if (rsp_data !== ed || rsp_id !== ei) begin failures++; $display("FAIL sb_rsp c=%0d got=%h/%0d want=%h/%0d", c, rsp_data, rsp_id, ed, ei); end
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               q_data.push_back(ref_itof(req_data[32*i +: 32]));
               q_id.push_back(2'(i));
            end
         end
         checks++; if (dut.cnt_reg > 3'(DEPTH) || $countones(req_ready) > 1) begin
            failures++; $display("FAIL sb_credit c=%0d cnt=%0d ready=%b want cnt<=%0d onehot", c, dut.cnt_reg, req_ready, DEPTH); end
         tick();
      end
      @(negedge clk);
      checks++; if (q_data.size() != 0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL sb_drain got=%0d left/%b want=0/0", q_data.size(), rsp_valid); end
      $display("test_pop_issue_same_cycle: drained, %0d left", q_data.size());
   endtask

   task automatic test_reset_midop();
      do_reset();
      rsp_ready = 1'b1; req_valid = 4'b0101; req_data[31:0] = 32'd7; req_data[95:64] = 32'd9;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_g0 got=%b want=0001", req_ready); end
      tick();
      @(negedge clk);
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL midrst_g1 got=%b want=0100", req_ready); end
      tick();
      req_valid = '0; rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale k=%0d got=%b/%h want=0", k, rsp_valid, rsp_data); end
         tick();
      end
      req_valid = 4'b1111;
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL midrst_rrptr got=%b want=0001", req_ready); end
      tick();
      req_valid = '0;
      $display("test_reset_midop done");
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_credit_stall();
      test_pop_issue_same_cycle();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
